// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle shift-add mult/multu unit that owns HI/LO and stalls the pipeline on hazards
module muldiv_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_EX,
    input  logic         signed_EX,
    input  logic [W-1:0] a_EX,
    input  logic [W-1:0] b_EX,
    input  logic         hilo_rd_EX,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state;
    logic [2*W-1:0] acc, mcand, res;
    logic [W-1:0] mplier, a_mag, b_mag;
    logic [CW-1:0] cnt;
    logic neg;
    always_comb begin
        a_mag = (signed_EX && a_EX[W-1]) ? -a_EX : a_EX;
        b_mag = (signed_EX && b_EX[W-1]) ? -b_EX : b_EX;
        res   = neg ? -acc : acc;
    end
    assign stall = busy & (hilo_rd_EX | start_EX);
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_EX) begin
                    mcand  <= {{W{1'b0}}, a_mag};
                    mplier <= b_mag;
                    neg    <= signed_EX & (a_EX[W-1] ^ b_EX[W-1]);
                    acc    <= '0;
                    cnt    <= CW'(W-1);
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= res[2*W-1:W];
                    lo    <= res[W-1:0];
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer with hand-computed products and cycle-exact timing
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst, start_EX, signed_EX, hilo_rd_EX;
    logic [31:0] a_EX, b_EX, hi, lo;
    logic stall, busy, done;
    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.W(32)) dut (
        .clk(clk), .rst(rst), .start_EX(start_EX), .signed_EX(signed_EX),
        .a_EX(a_EX), .b_EX(b_EX), .hilo_rd_EX(hilo_rd_EX),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el);
        int bcyc, dcnt, dpos;
        a_EX = a; b_EX = b; signed_EX = s; start_EX = 1'b1; hilo_rd_EX = 1'b0;
        #1;
        check({tag, "_stall_idle"}, stall, 0);
        bcyc = 0; dcnt = 0; dpos = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            start_EX = 1'b0; a_EX = $urandom; b_EX = $urandom; signed_EX = ~s;
            #1;
            if (done) begin dcnt++; dpos = i; end
            if (!busy) break;
            bcyc++;
        end
        check({tag, "_busy_cycles"}, bcyc, 33);
        check({tag, "_done_cnt"}, dcnt, 1);
        check({tag, "_done_pos"}, dpos, 33);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    initial begin
        int scnt, d1, d2, dcnt, bcyc;
        rst = 1'b1; start_EX = 1'b0; signed_EX = 1'b0; hilo_rd_EX = 1'b0; a_EX = '0; b_EX = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);

        run_op("multu_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m1x1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("mult_min", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
        run_op("multu_zero", 32'h00000000, 32'h12345678, 1'b0, 32'h0, 32'h0);
        run_op("mult_neg7x6", 32'hFFFFFFF9, 32'h00000006, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6);
        run_op("multu_big", 32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000);
        run_op("mult_mix", 32'h12345678, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hDB975310);

        // mult 7x6 with a dependent mfhi/mflo waiting in EX
        a_EX = 7; b_EX = 6; signed_EX = 1'b1; start_EX = 1'b1;
        #1;
        check("rd_stall_n", stall, 0);
        scnt = 0;
        for (int i = 1; i <= 34; i++) begin
            step();
            start_EX = 1'b0; hilo_rd_EX = 1'b1;
            #1;
            if (i <= 33 && stall) scnt++;
            if (i == 34) begin
                check("rd_stall_n34", stall, 0);
                check("rd_lo", lo, 42);
                check("rd_hi", hi, 0);
            end
        end
        check("rd_stall_cycles", scnt, 33);
        hilo_rd_EX = 1'b0;

        // back-to-back: start held high, operands churn mid-run
        a_EX = 3; b_EX = 5; signed_EX = 1'b0; start_EX = 1'b1;
        scnt = 0; d1 = 0; d2 = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            start_EX = (i <= 34);
            hilo_rd_EX = (i == 34);
            a_EX = (i == 33) ? 32'd9 : $urandom;
            b_EX = (i == 33) ? 32'd4 : $urandom;
            if (i == 34) begin a_EX = 9; b_EX = 4; end
            #1;
            if (i <= 33 && stall) scnt++;
            if (done) begin
                if (d1 == 0) d1 = i;
                else if (d2 == 0) d2 = i;
            end
            if (i == 34) begin
                check("b2b_idle_busy", busy, 0);
                check("b2b_idle_stall", stall, 0);
                check("b2b_first_lo", lo, 15);
                check("b2b_first_hi", hi, 0);
            end
        end
        check("b2b_stall_cycles", scnt, 33);
        check("b2b_done1", d1, 33);
        check("b2b_done2", d2, 67);
        check("b2b_second_lo", lo, 36);
        hilo_rd_EX = 1'b0;

        // reset mid-RUN aborts multu 5x5 with start also asserted
        a_EX = 5; b_EX = 5; signed_EX = 1'b0; start_EX = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            start_EX = 1'b0;
        end
        rst = 1'b1; start_EX = 1'b1;
        step();
        rst = 1'b0; start_EX = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_done", done, 0);
        dcnt = 0; bcyc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dcnt++;
            if (busy) bcyc++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_no_busy", bcyc, 0);

        // reset wins over a coincident start in IDLE
        a_EX = 3; b_EX = 3; start_EX = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start_EX = 1'b0;
        #1;
        check("rst_prio_busy", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dcnt++;
        end
        check("rst_prio_no_done", dcnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
